upsample2x_nn: RTL
==================

# upsample2x_nn

Nearest-neighbour 2x upsampler for one feature-map channel, the inverse of the 2x2/stride-2 max-pool stage. It accepts an IMG_SIZE x IMG_SIZE raster stream and emits a 2·IMG_SIZE x 2·IMG_SIZE raster stream. Every input pixel is emitted twice horizontally, and every input row is replayed from a line buffer to produce the second output row. Upsample layers instantiate it once per channel, in parallel, and AND the per-channel valid_out signals, as the pooling layers do.

## Interface
- DATA_WIDTH, 32: width of one pixel word (FP32 channel value).
- IMG_SIZE, 13: input width and height in pixels. Output is 2·IMG_SIZE square.
- Clk  in  1  single clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  input pixel, raster order.
- valid_in  in  1  data_in is valid.
- ready_in  out  1  block accepts data_in this cycle. A transfer occurs when valid_in & ready_in.
- data_out  out  DATA_WIDTH  output pixel, raster order, registered.
- valid_out  out  1  data_out is valid. Downstream always accepts; there is no backpressure.
- frame_end  out  1  one-cycle pulse coincident with the last output pixel of a frame.

## Operation
- Internal state: a line buffer of IMG_SIZE words, column counter col (0..IMG_SIZE-1), row counter row (0..IMG_SIZE-1), duplicate phase bit ph, and FSM state.
- FSM has two states, ROW_A (pass-through) and ROW_B (replay).
- ROW_A:
  - ready_in = 1 only when ph = 0.
  - On a transfer:
    - buf[col] <= data_in
    - data_out <= data_in
    - valid_out <= 1
    - ph <= 1
  - When ph = 1 (the next cycle, unconditionally):
    - valid_out <= 1 with data_out unchanged (second copy); ph <= 0.
    - If col = IMG_SIZE-1: col <= 0 and go to ROW_B. Otherwise col++.
  - When ph = 0 with no transfer: valid_out <= 0.
- ROW_B:
  - ready_in = 0.
  - Every cycle valid_out <= 1 and data_out <= buf[col]. The same word is held for the ph = 0 and ph = 1 cycles.
  - After the ph = 1 cycle with col = IMG_SIZE-1, go to ROW_A with col <= 0.
  - On that transition: if row = IMG_SIZE-1 then row <= 0 and frame_end <= 1; otherwise row++.
- Arithmetic: counters are $clog2(IMG_SIZE)+1 bits with an explicit terminal-count compare, not a power-of-2 wrap. Data is copied bit-exactly with no arithmetic.
- Per frame: exactly IMG_SIZE² transfers in and 4·IMG_SIZE² valid_out cycles out.

## Timing
- Reset values: state = ROW_A, col = 0, row = 0, ph = 0, data_out = 0, valid_out = 0, frame_end = 0, ready_in = 1. The line buffer is not reset.
- Latency: the first copy appears on the cycle after the transfer edge, and the second copy on the cycle after that.
- ready_in is combinational from state and ph only. It never depends on valid_in.
- Throughput with continuous valid_in:
  - Input: 1 pixel per 2 cycles in ROW_A, 0 in ROW_B.
  - Output: 1 pixel per cycle, gap-free across the ROW_A→ROW_B→ROW_A boundaries.
- Input stalls: valid_in low in ROW_A with ph = 0 produces valid_out bubbles. A stall never occurs mid-pair; the second copy always follows its first.
- Reset mid-row or mid-replay aborts the frame immediately. After release, the next transfer is treated as pixel (0,0).
- Within ROW_B, frame_end is high only on the final ph = 1 cycle of row IMG_SIZE-1.

## Structure
- State encoding localparams (ROW_A = 1'b0, ROW_B = 1'b1) go in the shared YOLOv3Tiny layer package, alongside the pooling layer constants.
- Sub-module upsample_line_buffer: an IMG_SIZE x DATA_WIDTH register array with one write port and one combinational read port. The FSM and counters stay in upsample2x_nn.
- The layer wrapper instantiates 32 copies per 1024-bit bus and ANDs their valid_out and ready_in signals.

## Test plan
- Reset: hold Rst = 0 with random valid_in/data_in.
  - Required: valid_out = 0, frame_end = 0, data_out = 0, ready_in = 1 throughout.
- Single row: IMG_SIZE = 4, continuous inputs 1, 2, 3, 4.
  - Required data_out over 16 consecutive cycles: 1,1,2,2,3,3,4,4,1,1,2,2,3,3,4,4.
  - Required: ready_in low on odd cycles and for all 8 ROW_B cycles.
- Full frame: IMG_SIZE = 4, input value = 10·r + c, continuous.
  - Required: 64 outputs; output (R,C) = 10·(R/2) + C/2.
  - Required: frame_end exactly once, on output 64.
- Input gaps: IMG_SIZE = 4, valid_in randomly deasserted 50%.
  - Required: same 64-value sequence as the full-frame test, with bubbles only at ph = 0 points; pairs are never split.
- Back-to-back frames: two frames fed continuously.
  - Required: no output gap between frames; the second frame's first output equals its pixel (0,0).
- Mid-operation reset: assert Rst during the ROW_B replay of row 1, then restart the frame.
  - Required: outputs restart at (0,0); frame_end fires after exactly 64 post-reset outputs.

Source files
------------

// File: rtl/upsample2x_nn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : upsample2x_nn_pkg
// Brief   : Shared layer types and constants for the pooling/upsample stages.
// Revision: 1.0 - initial release
// ============================================================================
package upsample2x_nn_pkg;

   // Upsampler row phase: ROW_A passes pixels through, ROW_B replays the line.
   typedef enum logic {
      ROW_A = 1'b0,
      ROW_B = 1'b1
   } us_state_e;

   localparam int POOL_SIZE       = 2;
   localparam int POOL_STRIDE     = 2;
   localparam int UPSAMPLE_FACTOR = 2;

   // Counters carry one spare bit so terminal count is an explicit compare.
   function automatic int ctr_width(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/upsample2x_nn_if.sv
`default_nettype none
// ============================================================================
// Module  : upsample2x_nn_if
// Brief   : Pixel-stream handshake bundle for one upsampler channel.
// Revision: 1.0 - initial release
// ============================================================================
interface upsample2x_nn_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic                  ready_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  frame_end;

   modport master (
      output data_in,
      output valid_in,
      input  ready_in,
      input  data_out,
      input  valid_out,
      input  frame_end
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output ready_in,
      output data_out,
      output valid_out,
      output frame_end
   );
endinterface
`default_nettype wire

// File: rtl/upsample2x_nn_line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : upsample_line_buffer
// Brief   : One-row register array, one write port, combinational read port.
// Revision: 1.0 - initial release
// ============================================================================
module upsample_line_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 13,
   parameter int AW         = 4
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   // Contents are fully rewritten before every replay, so no reset is needed.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/upsample2x_nn.sv
`default_nettype none
// ============================================================================
// Module  : upsample2x_nn
// Brief   : Nearest-neighbour 2x upsampler for one channel raster stream.
// Revision: 1.0 - initial release
// ============================================================================
module upsample2x_nn
   import upsample2x_nn_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_SIZE   = 13
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   upsample2x_nn_if.slave bus
);
   localparam int            CW   = ctr_width(IMG_SIZE);
   localparam int            AW   = addr_width(IMG_SIZE);
   localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

   us_state_e             state_q, state_d;
   logic [CW-1:0]         col_q, col_d;
   logic [CW-1:0]         row_q, row_d;
   logic                  ph_q, ph_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  frame_end_q, frame_end_d;

   logic                  ready;
   logic                  xfer;
   logic                  buf_we;
   logic [DATA_WIDTH-1:0] buf_rdata;
   logic                  col_last;
   logic                  row_last;

   assign ready    = (state_q == ROW_A) && !ph_q;
   assign xfer     = bus.valid_in && ready;
   assign col_last = (col_q == LAST);
   assign row_last = (row_q == LAST);

   upsample_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_SIZE),
      .AW         (AW)
   ) u_line_buffer (
      .clk_i   (clk_i),
      .we_i    (buf_we),
      .waddr_i (col_q[AW-1:0]),
      .wdata_i (bus.data_in),
      .raddr_i (col_q[AW-1:0]),
      .rdata_o (buf_rdata)
   );

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      ph_d        = ph_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_end_d = 1'b0;
      buf_we      = 1'b0;

      case (state_q)
         ROW_A: begin
            if (ph_q) begin
               // Second copy: data_q is simply held.
               valid_d = 1'b1;
               ph_d    = 1'b0;
               if (col_last) begin
                  col_d   = '0;
                  state_d = ROW_B;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end else if (xfer) begin
               buf_we  = 1'b1;
               data_d  = bus.data_in;
               valid_d = 1'b1;
               ph_d    = 1'b1;
            end
         end
         ROW_B: begin
            valid_d = 1'b1;
            data_d  = buf_rdata;
            ph_d    = ~ph_q;
            if (ph_q) begin
               if (col_last) begin
                  col_d   = '0;
                  state_d = ROW_A;
                  if (row_last) begin
                     row_d       = '0;
                     frame_end_d = 1'b1;
                  end else begin
                     row_d = row_q + CW'(1);
                  end
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         default: state_d = ROW_A;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ROW_A;
         col_q       <= '0;
         row_q       <= '0;
         ph_q        <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         ph_q        <= ph_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign bus.ready_in  = ready;
   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.frame_end = frame_end_q;

endmodule
`default_nettype wire
